// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, fixed-latency memory between the
// instruction-fetch side (I) and the data side (D) of the pipelined CPU.
// One access is in flight at a time. D has priority, and a starvation counter
// forces an I grant after STARVE_MAX consecutive D grants taken while I waited.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   hlt                        blocks new grants; an access already started completes
//   i_req/i_addr               fetch request; held until i_rdy
//   i_rdy/i_rdata              one-cycle completion pulse; fetch data (held)
//   d_req/d_we/d_addr/d_wdata  data request; held until d_rdy
//   d_rdy/d_rdata              one-cycle completion pulse; read data (D reads only)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory-side interface
//   busy                       high whenever the arbiter is not idle
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MEM_LAT    = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hlt,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rdy,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rdy,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned LAT_W = $clog2(MEM_LAT + 1);
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  state_t            state_q,    state_d;
  owner_t            owner_q,    owner_d;
  logic [LAT_W-1:0]  lat_cnt_q,  lat_cnt_d;
  logic [STV_W-1:0]  starve_q,   starve_d;

  logic              mem_en_d;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              i_rdy_d;
  logic              d_rdy_d;
  logic [DATA_W-1:0] i_rdata_d;
  logic [DATA_W-1:0] d_rdata_d;
  logic              busy_d;

  // I wins when D is absent, or when I has been passed over STARVE_MAX times
  logic pick_i_c;
  assign pick_i_c = i_req && (!d_req || (starve_q == STV_W'(STARVE_MAX)));

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_I;
      lat_cnt_q <= '0;
      starve_q  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdy     <= 1'b0;
      d_rdy     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      lat_cnt_q <= lat_cnt_d;
      starve_q  <= starve_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      i_rdy     <= i_rdy_d;
      d_rdy     <= d_rdy_d;
      i_rdata   <= i_rdata_d;
      d_rdata   <= d_rdata_d;
      busy      <= busy_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_cnt_d   = lat_cnt_q;
    starve_d    = starve_q;
    mem_en_d    = mem_en;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    i_rdy_d     = 1'b0;
    d_rdy_d     = 1'b0;
    i_rdata_d   = i_rdata;
    d_rdata_d   = d_rdata;

    unique case (state_q)
      ST_IDLE: begin
        if (!i_req) begin
          starve_d = '0;
        end
        if (!hlt && (i_req || d_req)) begin
          state_d   = ST_ACCESS;
          lat_cnt_d = LAT_W'(1);
          mem_en_d  = 1'b1;
          if (pick_i_c) begin
            owner_d     = OWN_I;
            mem_we_d    = 1'b0;
            mem_addr_d  = i_addr;
            mem_wdata_d = '0;
            starve_d    = '0;
          end else begin
            owner_d     = OWN_D;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            // pick_i_c being false with i_req set means starve_q < STARVE_MAX
            if (i_req) begin
              starve_d = starve_q + STV_W'(1);
            end
          end
        end
      end

      ST_ACCESS: begin
        if (lat_cnt_q == LAT_W'(MEM_LAT)) begin
          state_d   = ST_RESP;
          lat_cnt_d = '0;
          mem_en_d  = 1'b0;
          mem_we_d  = 1'b0;
          if (owner_q == OWN_I) begin
            i_rdata_d = mem_rdata;
            i_rdy_d   = 1'b1;
          end else begin
            if (!mem_we) begin
              d_rdata_d = mem_rdata;
            end
            d_rdy_d = 1'b1;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a transaction-level model predicts every
// cycle's outputs from grant times, plus directed literal checks.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned L  = 4;
  localparam int unsigned SM = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          hlt = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_rdy;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_rdy;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L), .STARVE_MAX(SM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hlt(hlt),
    .i_req(i_req), .i_addr(i_addr), .i_rdy(i_rdy), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdy(d_rdy), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Memory contents, indexed by the low address byte
  logic [DW-1:0] mem_arr [256];

  always_comb begin
    mem_rdata = mem_en ? mem_arr[mem_addr[7:0]] : '0;
  end

  // Transaction model: a grant decided at the end of cycle g occupies
  // cycles g+1..g+L with mem_en, rdy in g+L+1, idle again from g+L+2.
  int unsigned   cyc = 0;
  bit            act = 1'b0;
  int unsigned   g_cyc = 0;
  int unsigned   free_at = 0;
  bit            g_i = 1'b0;
  bit            g_we = 1'b0;
  logic [AW-1:0] g_addr = '0;
  logic [DW-1:0] g_wdata = '0;
  int unsigned   starve = 0;
  logic [DW-1:0] m_irdata = '0;
  logic [DW-1:0] m_drdata = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      act      <= 1'b0;
      free_at  <= 0;
      starve   <= 0;
      m_irdata <= '0;
      m_drdata <= '0;
      for (int i = 0; i < 256; i++) mem_arr[i] <= DW'(i * 257) ^ 16'h0F0F;
      mem_arr[8'h00] <= 16'h5555;
      mem_arr[8'h10] <= 16'hABCD;
      mem_arr[8'h20] <= 16'h7777;
      mem_arr[8'h40] <= 16'h4444;
    end else begin
      if (act && cyc == g_cyc + L) begin
        if (g_we)     mem_arr[g_addr[7:0]] <= g_wdata;
        else if (g_i) m_irdata <= mem_arr[g_addr[7:0]];
        else          m_drdata <= mem_arr[g_addr[7:0]];
      end
      if (cyc >= free_at) begin
        if (!hlt && (i_req || d_req)) begin
          act     <= 1'b1;
          g_cyc   <= cyc;
          free_at <= cyc + L + 2;
          if (i_req && (!d_req || starve == SM)) begin
            g_i <= 1'b1; g_we <= 1'b0; g_addr <= i_addr; g_wdata <= '0;
            starve <= 0;
          end else begin
            g_i <= 1'b0; g_we <= d_we; g_addr <= d_addr; g_wdata <= d_wdata;
            starve <= !i_req ? 0 : ((starve + 1 > SM) ? SM : starve + 1);
          end
        end else if (!i_req) begin
          starve <= 0;
        end
      end
    end
  end

  bit e_en, e_rdy, e_busy;
  always_comb begin
    e_en   = act && (cyc >= g_cyc + 1) && (cyc <= g_cyc + L);
    e_rdy  = act && (cyc == g_cyc + L + 1);
    e_busy = act && (cyc >= g_cyc + 1) && (cyc <= g_cyc + L + 1);
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_i_rdy", 32'(i_rdy), 32'd0);
      chk("rst_d_rdy", 32'(d_rdy), 32'd0);
      chk("rst_i_rdata", 32'(i_rdata), 32'd0);
      chk("rst_d_rdata", 32'(d_rdata), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end else begin
      chk("mdl_mem_en", 32'(mem_en), 32'(e_en));
      chk("mdl_mem_we", 32'(mem_we), 32'(e_en && g_we));
      chk("mdl_busy", 32'(busy), 32'(e_busy));
      chk("mdl_i_rdy", 32'(i_rdy), 32'(e_rdy && g_i));
      chk("mdl_d_rdy", 32'(d_rdy), 32'(e_rdy && !g_i));
      chk("mdl_i_rdata", 32'(i_rdata), 32'(m_irdata));
      chk("mdl_d_rdata", 32'(d_rdata), 32'(m_drdata));
      if (e_en) chk("mdl_mem_addr", 32'(mem_addr), 32'(g_addr));
      if (e_en && g_we) chk("mdl_mem_wdata", 32'(mem_wdata), 32'(g_wdata));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Steps until the chosen rdy pulses (bounded); leaves us in the RESP cycle
  task automatic wait_rdy(input bit is_i, input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      seen = is_i ? i_rdy : d_rdy;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  initial begin
    bit [4:0] seq;
    int       nrdy;

    // 1: reset held with both requests pending
    i_req = 1'b1; i_addr = 16'h0090;
    d_req = 1'b1; d_addr = 16'h0080;
    #1 rst_n = 1'b0;
    repeat (3) step();
    chk("t1_rst_mem_en", 32'(mem_en), 32'd0);
    chk("t1_rst_busy", 32'(busy), 32'd0);
    chk("t1_rst_rdy", 32'({i_rdy, d_rdy}), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    step();
    chk("t1_no_grant_yet", 32'(mem_en), 32'd0);
    step();
    chk("t1_grant_en", 32'(mem_en), 32'd1);
    chk("t1_grant_addr", 32'(mem_addr), 32'h0080);
    wait_rdy(1'b0, "t1_d_done");
    d_req = 1'b0;
    wait_rdy(1'b1, "t1_i_done");
    i_req = 1'b0;
    step();

    // 2: single I read
    i_req = 1'b1; i_addr = 16'h0010;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("t2_mem_en", 32'(mem_en), 32'(k <= 4));
      chk("t2_i_rdy", 32'(i_rdy), 32'(k == 5));
      if (k == 1) begin
        chk("t2_mem_addr", 32'(mem_addr), 32'h0010);
        chk("t2_mem_we", 32'(mem_we), 32'd0);
      end
      if (k == 5) begin
        chk("t2_i_rdata", 32'(i_rdata), 32'hABCD);
        i_req = 1'b0;
      end
    end

    // 3: simultaneous requests, D first then I
    i_req = 1'b1; i_addr = 16'h0020;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100;
    for (int k = 1; k <= 11; k++) begin
      step();
      chk("t3_mem_en", 32'(mem_en), 32'((k >= 1 && k <= 4) || (k >= 7 && k <= 10)));
      chk("t3_d_rdy", 32'(d_rdy), 32'(k == 5));
      chk("t3_i_rdy", 32'(i_rdy), 32'(k == 11));
      if (k == 5) begin
        chk("t3_d_rdata", 32'(d_rdata), 32'h5555);
        d_req = 1'b0;
      end
      if (k == 11) begin
        chk("t3_i_rdata", 32'(i_rdata), 32'h7777);
        i_req = 1'b0;
      end
    end
    step();

    // 4: starvation forces an I grant after three D grants
    i_req = 1'b1; i_addr = 16'h0050;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
    seq  = '0;
    nrdy = 0;
    for (int k = 0; k < 60 && nrdy < 5; k++) begin
      step();
      if (i_rdy || d_rdy) begin
        seq  = {seq[3:0], i_rdy};
        nrdy = nrdy + 1;
      end
    end
    chk("t4_nrdy", 32'(nrdy), 32'd5);
    chk("t4_order_DDDID", 32'(seq), 32'b00010);
    i_req = 1'b0; d_req = 1'b0;
    step();

    // 5: D write
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0030; d_wdata = 16'h1234;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("t5_mem_en", 32'(mem_en), 32'(k <= 4));
      chk("t5_mem_we", 32'(mem_we), 32'(k <= 4));
      chk("t5_d_rdy", 32'(d_rdy), 32'(k == 5));
      if (k == 1) begin
        chk("t5_mem_wdata", 32'(mem_wdata), 32'h1234);
        chk("t5_mem_addr", 32'(mem_addr), 32'h0030);
      end
      if (k == 5) begin
        chk("t5_d_rdata_kept", 32'(d_rdata), 32'h4444);
        d_req = 1'b0; d_we = 1'b0;
      end
    end

    // 6a: reset in the middle of an access
    i_req = 1'b1; i_addr = 16'h0060;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0; i_req = 1'b0;
    #1;
    chk("t6_rst_mem_en", 32'(mem_en), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    repeat (2) step();
    @(posedge clk); #2 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t6_no_rdy", 32'({i_rdy, d_rdy}), 32'd0);
    end

    // 6b: hlt blocks grants in IDLE but not an access in flight
    hlt = 1'b1;
    i_req = 1'b1; i_addr = 16'h0060;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0070;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t6_hlt_idle", 32'(busy), 32'd0);
    end
    hlt = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) chk("t6_grant_addr", 32'(mem_addr), 32'h0070);
      if (k == 2) hlt = 1'b1;
      chk("t6_hlt_mem_en", 32'(mem_en), 32'(k <= 4));
      chk("t6_hlt_d_rdy", 32'(d_rdy), 32'(k == 5));
      if (k == 5) d_req = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_hlt_hold", 32'(busy), 32'd0);
    end
    hlt = 1'b0;
    wait_rdy(1'b1, "t6_i_after_hlt");
    i_req = 1'b0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
